// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store sequencer. Turns a LOAD/STORE held in the MEM stage
//   into one req/ack data-memory transaction. It stalls upstream while the
//   access is in flight and returns aligned, extended load data to write-back.
//   Misaligned accesses, illegal func3 values and bus timeouts are reported.
//   All state updates on the falling edge of clk.
//
// Ports
//   clk         in   clock (falling edge active)
//   reset       in   asynchronous, active-low reset
//   opcode      in   [6:0]  MEM-stage opcode
//   func3       in   [2:0]  MEM-stage func3
//   valid       in          MEM-stage instruction valid
//   addr        in   [31:0] effective byte address
//   store_data  in   [31:0] rs2 value
//   mem_req     out         bus request, held until ack or timeout
//   mem_we      out         1 = write
//   mem_addr    out  [31:0] word-aligned address
//   mem_wdata   out  [31:0] lane-replicated store data
//   mem_wstrb   out  [3:0]  byte enables (0 for loads)
//   mem_ack     in          single-cycle bus completion
//   mem_rdata   in   [31:0] read word, valid with mem_ack
//   load_data   out  [31:0] extended load result
//   done        out         one-cycle completion pulse
//   stall       out         freeze upstream stages
//   fault       out         one-cycle fault pulse
//   fault_code  out  [1:0]  1 misaligned, 2 illegal func3, 3 bus timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  cnt_q, cnt_d;
  // Load format and byte lane are captured at request time so the
  // extension at ack does not depend on upstream holding its inputs.
  logic [2:0]  ld_func3_q, ld_func3_d;
  logic [1:0]  lane_q, lane_d;

  // ---------------------------------------------------------------------------
  // Decode of the MEM-stage instruction
  // ---------------------------------------------------------------------------
  logic        is_load, is_store, mem_op, legal, misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    mem_op   = valid && (is_load || is_store);

    legal = 1'b0;
    if (is_load) begin
      case (func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    end

    // func3[1:0] encodes the access size for every legal encoding.
    misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    case (func3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------------
  logic [31:0] rd_shifted, ld_ext;

  always_comb begin
    rd_shifted = mem_rdata >> {lane_q, 3'b000};
    case (ld_func3_q)
      3'b000:  ld_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  ld_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  ld_ext = {24'h0, rd_shifted[7:0]};
      3'b101:  ld_ext = {16'h0, rd_shifted[15:0]};
      default: ld_ext = rd_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      load_data_q  <= 32'h0;
      fault_code_q <= 2'h0;
      cnt_q        <= 8'h0;
      ld_func3_q   <= 3'h0;
      lane_q       <= 2'h0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      load_data_q  <= load_data_d;
      fault_code_q <= fault_code_d;
      cnt_q        <= cnt_d;
      ld_func3_q   <= ld_func3_d;
      lane_q       <= lane_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    load_data_d  = load_data_q;
    fault_code_d = fault_code_q;
    cnt_d        = cnt_q;
    ld_func3_d   = ld_func3_q;
    lane_d       = lane_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'h0;
        if (mem_op) begin
          // Illegal func3 takes priority: its size bits are meaningless.
          if (!legal) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd2;
          end else if (misaligned) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd1;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = is_store ? st_wstrb : 4'h0;
            ld_func3_d  = func3;
            lane_d      = addr[1:0];
          end
        end
      end
      S_ACCESS: begin
        // An ack arriving on the last allowed cycle still completes.
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = 8'h0;
          if (!mem_we_q) begin
            load_data_d = ld_ext;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'd3;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          cnt_d        = 8'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d      = S_IDLE;
        fault_code_d = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign load_data  = load_data_q;
  assign fault_code = fault_code_q;
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign stall      = ((state_q == S_IDLE) && mem_op) || (state_q == S_ACCESS);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer. Consumes the MEM-stage opcode/func3, ALU address and store data, and runs one data-memory transaction over a req/ack bus.
- Returns aligned, sign/zero-extended load data to write-back.
- Stalls the pipeline while a transaction is in flight.
- Reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 15, max cycles in ACCESS without mem_ack before bus-timeout fault (1..255)

Ports:
clk  input  1  clock; all state updates on the falling edge, like the other stage registers
reset  input  1  asynchronous, active-low reset
opcode  input  7  MEM-stage opcode
func3  input  3  MEM-stage func3
valid  input  1  MEM-stage instruction valid
addr  input  32  effective byte address from ALU
store_data  input  32  rs2 value
mem_req  output  1  bus request, held until ack
mem_we  output  1  1=write
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte enables
mem_ack  input  1  bus completion, single-cycle pulse
mem_rdata  input  32  read word, valid with mem_ack
load_data  output  32  extended load result, valid while done=1
done  output  1  one-cycle completion pulse
stall  output  1  freeze upstream stages
fault  output  1  one-cycle fault pulse
fault_code  output  2  1=misaligned, 2=illegal func3, 3=bus timeout; 0 otherwise

Behaviour:
- Reset (async, reset=0): state IDLE; mem_req, mem_we, done, fault, stall = 0; mem_addr, mem_wdata, load_data = 0; mem_wstrb = 0; fault_code = 0; timeout counter = 0.
- Reset mid-transaction drops mem_req immediately; any late ack is ignored.
- Memory op: valid=1 with opcode 0000011 (LOAD) or 0100011 (STORE).
- Other opcodes, or valid=0: no action, stall=0, done=0.
- Legal func3:
  - LOAD: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - STORE: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal.
- Misaligned: H-type with addr[0]=1; W-type with addr[1:0]!=0.
- FSM states: IDLE, ACCESS, DONE, FAULT.
  - IDLE with memory op:
    - If illegal or misaligned -> FAULT; no mem_req is ever issued.
    - Else -> ACCESS; mem_req=1, mem_we=STORE, mem_addr, mem_wdata and mem_wstrb registered on the same edge.
  - ACCESS with mem_ack=1 -> DONE. mem_req drops on that edge. For loads, load_data is captured from mem_rdata.
  - ACCESS without ack: counter increments each cycle. When counter reaches TIMEOUT -> FAULT with code 3; mem_req drops.
  - ACCESS with ack in the same cycle the counter reaches TIMEOUT: ack wins -> DONE.
  - DONE: done=1 for one cycle, then IDLE. load_data holds its value until the next load completes.
  - FAULT: fault=1 and fault_code valid for one cycle, then IDLE; fault_code then returns to 0.
- stall (combinational) = (IDLE and memory op) or ACCESS. It is 0 in DONE/FAULT, so the instruction retires there. A memory op is accepted only from IDLE, giving one bubble minimum per access.
- Upstream holds opcode, func3, addr and store_data stable while stall=1. Changes during ACCESS are ignored, because the bus outputs are registered.
- Store lanes, with k=addr[1:0]:
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<k.
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<k.
  - SW: wdata=sd, wstrb=1111.
- Loads: mem_wstrb=0. Extract lane rdata>>(8*k). LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Minimum latency: a zero-wait ack (ack the cycle after req) gives request edge -> DONE after 2 falling edges.

Test Plan:
- LW addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000, stall high 4 cycles, done pulse, load_data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80112233 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x202 -> 0x00008011.
- SB addr=0x301, sd=0x000000A5 -> mem_we=1, mem_addr=0x300, wdata=0xA5A5A5A5, wstrb=0010; SH addr=0x302, sd=0x1234 -> wstrb=1100, wdata=0x12341234.
- LW addr=0x102 -> no mem_req, fault=1, fault_code=1; STORE func3=011 -> fault_code=2.
- TIMEOUT=15, no ack -> mem_req high exactly 15 cycles then fault_code=3, stall drops; ack on cycle 15 instead -> done, no fault.
- reset asserted during ACCESS -> mem_req=0 immediately, state IDLE; after release, a following LW completes normally.
